pixel_load_cmd_ctrl: RTL and testbench
======================================

// Module: pixel_load_cmd_ctrl
// PURPOSE
//  Parametrised successor of the top-level load/run sequencer. Packs an 8-bit pixel byte stream
//  (valid/ready, SDRAM-FIFO side) into PIXEL_BYTES-wide words and writes N_PIXELS of them to image
//  memory. It then assembles HPS byte writes into CMD_BYTES-wide render commands with a
//  valid/ready output. An HPS clear code restarts loading after any pending command drains.
// PARAMETERS
//  PIXEL_BYTES  3      bytes per pixel word; first byte received -> MSB
//  N_PIXELS     512    pixels loaded per load phase
//  ADDR_W       9      image memory address width, 2**ADDR_W >= N_PIXELS
//  CMD_BYTES    6      bytes per render command; HPS address 0 -> MSB
//  HPS_ADDR_W   3      HPS address width, 2**HPS_ADDR_W > CMD_BYTES
//  CLEAR_CODE   8'hFE  byte at HPS address 0 that requests clear/reload
// PORTS
//  clk50           in   1                single clock, all logic on posedge
//  reset           in   1                synchronous, active-high
//  src_valid       in   1                pixel byte valid
//  src_data        in   8                pixel byte
//  src_ready       out  1                byte accepted when src_valid & src_ready
//  mem_we          out  1                image memory write strobe, one cycle per pixel
//  mem_addr        out  ADDR_W           image memory address
//  mem_din         out  8*PIXEL_BYTES    packed pixel word
//  hps_write       in   1                HPS write strobe
//  hps_chipselect  in   1                HPS select; writes need both strobes
//  hps_address     in   HPS_ADDR_W       byte slot
//  hps_writedata   in   8                byte data
//  cmd_valid       out  1                render command pending
//  cmd_data        out  8*CMD_BYTES      render command, stable while cmd_valid
//  cmd_ready       in   1                consumer accepts when cmd_valid & cmd_ready
//  loading         out  1                high in LOAD state
//  load_done       out  1                one-cycle pulse when the load phase completes
// BEHAVIOUR
//  - Reset: state=LOAD; all outputs 0 except loading=1 and src_ready=1; pixel/byte counters,
//    assembly register and overflow flag 0. Reset mid-load or mid-command discards everything.
//  - States: LOAD -> RUN (last pixel written); RUN -> FLUSH (clear code);
//    FLUSH -> LOAD (once cmd_valid=0); RUN -> LOAD directly if clear arrives with cmd_valid=0.
//  - LOAD: src_ready=1. byte_cnt counts 0..PIXEL_BYTES-1, then wraps to 0.
//    Handshake on the last byte -> next cycle: mem_we=1, mem_din=packed word, mem_addr=pixel_cnt;
//    then pixel_cnt++. No stall between pixels.
//  - After mem_we for pixel N_PIXELS-1: next cycle state=RUN, load_done=1 for one cycle,
//    src_ready=0 and loading=0.
//  - src_ready=0 outside LOAD. Bytes offered then are not consumed.
//  - HPS writes during LOAD/FLUSH are ignored, including the clear code.
//  - RUN: a write to address k<CMD_BYTES stores byte k; a write to k>=CMD_BYTES is ignored.
//    A write to k=CMD_BYTES-1 commits: next cycle cmd_valid=1 and cmd_data=assembled word
//    including that byte. Slots persist, so later commands may rewrite only some bytes.
//  - cmd_valid holds until accepted. Commit with cmd_valid & ~cmd_ready -> new command dropped,
//    overflow flag set (sticky). Commit in the same cycle as cmd_ready -> new command loaded,
//    cmd_valid stays 1.
//  - Clear: writedata==CLEAR_CODE at address 0 in RUN. The byte is not stored and has priority.
//    Entering LOAD zeroes counters and assembly slots; overflow is preserved.
//    FLUSH keeps cmd_valid and waits for cmd_ready.
//  - Counters use ADDR_W bits and never wrap within a phase; byte_cnt uses clog2(PIXEL_BYTES) bits.
// CONFIGURATION
//  LOADER_STATUS_EN defined: adds ports hps_read (in, 1) and hps_readdata (out, 8).
//    A read at address 2**HPS_ADDR_W-1 returns {loading, cmd_valid, overflow, state[1:0], 3'b0}
//    one cycle later. That read clears overflow; a same-cycle overflow event wins.
//    hps_readdata is 0 at reset and for other addresses.
//  Undefined: no read ports; overflow drops are silent and no flag register is built.
// TESTING
//  - Reset, stream 1536 bytes 0x00.. with src_valid=1 -> 512 mem_we pulses; addr 0 gets
//    24'h000102; addr 511 gets 24'hFDFEFF; load_done pulses once; loading falls with it.
//  - src_valid toggles every other cycle during the load -> correct packing; no mem_we mid-pixel.
//  - RUN, write addr 0..5 = 11..66 (cmd_ready=0) -> cmd_valid next cycle, cmd_data=48'h112233445566,
//    held until cmd_ready=1.
//  - Commit again while pending, cmd_ready=0 -> cmd_data unchanged; status read shows overflow=1,
//    then 0 on the next read (LOADER_STATUS_EN).
//  - Clear code with a command pending -> FLUSH; assert cmd_ready -> LOAD, src_ready=1, mem_addr
//    restarts at 0.
//  - Assert reset during pixel 100 of a load -> all outputs reset; the reload restarts at addr 0.

Source files
------------

// File: rtl/pixel_load_cmd_ctrl.sv
// Load/run sequencer: packs a pixel byte stream into image memory, then assembles HPS byte writes
// into render commands. Optional status read port and overflow flag under LOADER_STATUS_EN.
module pixel_load_cmd_ctrl #(
  parameter int unsigned PIXEL_BYTES = 3,
  parameter int unsigned N_PIXELS    = 512,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned CMD_BYTES   = 6,
  parameter int unsigned HPS_ADDR_W  = 3,
  parameter logic [7:0]  CLEAR_CODE  = 8'hFE
) (
  input  logic                     clk50,
  input  logic                     reset,
  input  logic                     src_valid,
  input  logic [7:0]               src_data,
  output logic                     src_ready,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [8*PIXEL_BYTES-1:0] mem_din,
  input  logic                     hps_write,
  input  logic                     hps_chipselect,
  input  logic [HPS_ADDR_W-1:0]    hps_address,
  input  logic [7:0]               hps_writedata,
  output logic                     cmd_valid,
  output logic [8*CMD_BYTES-1:0]   cmd_data,
  input  logic                     cmd_ready,
  output logic                     loading,
  output logic                     load_done
`ifdef LOADER_STATUS_EN
  ,
  input  logic                     hps_read,
  output logic [7:0]               hps_readdata
`endif
);

  localparam int unsigned PIX_W = 8 * PIXEL_BYTES;
  localparam int unsigned CMD_W = 8 * CMD_BYTES;
  localparam int unsigned BC_W  = (PIXEL_BYTES > 1) ? $clog2(PIXEL_BYTES) : 1;
  localparam int unsigned PSR_W = (PIXEL_BYTES > 1) ? 8 * (PIXEL_BYTES - 1) : 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BC_W-1:0]     byte_cnt;
  logic [ADDR_W-1:0]   pixel_cnt;
  logic [PSR_W-1:0]    pix_sr;
  logic [PSR_W+7:0]    pix_cat;
  logic [CMD_W-1:0]    cmd_asm;
  logic [CMD_W-1:0]    asm_nxt;
  logic                hs;
  logic                hps_wr;
  logic                clear_req;
  logic                slot_wr;
  logic                commit;
  logic                cmd_load;
  logic                last_wr;
  logic                pix_done;
  logic                enter_load;

  assign pix_cat = {pix_sr, src_data};

  // Next-state and datapath control decode
  always_comb begin
    state_nxt = state;
    asm_nxt   = cmd_asm;
    hs        = src_valid && src_ready;
    hps_wr    = hps_write && hps_chipselect;
    clear_req = (state == ST_RUN) && hps_wr && (hps_address == '0) && (hps_writedata == CLEAR_CODE);
    slot_wr   = (state == ST_RUN) && hps_wr && !clear_req &&
                (hps_address < HPS_ADDR_W'(CMD_BYTES));
    commit    = slot_wr && (hps_address == HPS_ADDR_W'(CMD_BYTES - 1));
    cmd_load  = commit && (!cmd_valid || cmd_ready);
    last_wr   = (state == ST_LOAD) && mem_we && (mem_addr == ADDR_W'(N_PIXELS - 1));
    pix_done  = hs && (byte_cnt == BC_W'(PIXEL_BYTES - 1)) && !last_wr;

    for (int k = 0; k < CMD_BYTES; k++) begin
      if (slot_wr && (hps_address == HPS_ADDR_W'(k))) begin
        asm_nxt[8*(CMD_BYTES-1-k) +: 8] = hps_writedata;
      end
    end

    case (state)
      ST_LOAD:  if (last_wr) state_nxt = ST_RUN;
      ST_RUN:   if (clear_req) state_nxt = cmd_valid ? ST_FLUSH : ST_LOAD;
      ST_FLUSH: if (!cmd_valid) state_nxt = ST_LOAD;
      default:  state_nxt = ST_LOAD;
    endcase

    enter_load = (state != ST_LOAD) && (state_nxt == ST_LOAD);
  end

  always_ff @(posedge clk50) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  // Registered outputs, counters and assembly storage
  always_ff @(posedge clk50) begin
    if (reset) begin
      src_ready <= 1'b1;
      loading   <= 1'b1;
      load_done <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      byte_cnt  <= '0;
      pixel_cnt <= '0;
      pix_sr    <= '0;
      cmd_asm   <= '0;
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
    end else begin
      src_ready <= (state_nxt == ST_LOAD);
      loading   <= (state_nxt == ST_LOAD);
      load_done <= (state == ST_LOAD) && (state_nxt == ST_RUN);
      mem_we    <= pix_done;
      if (pix_done) begin
        mem_addr <= pixel_cnt;
        mem_din  <= pix_cat[PIX_W-1:0];
      end

      if (enter_load) begin
        byte_cnt  <= '0;
        pixel_cnt <= '0;
        pix_sr    <= '0;
        cmd_asm   <= '0;
      end else begin
        if (hs) begin
          byte_cnt <= (byte_cnt == BC_W'(PIXEL_BYTES - 1)) ? '0 : byte_cnt + BC_W'(1);
          pix_sr   <= pix_cat[PSR_W-1:0];
        end
        // Hold at the last address so the counter never wraps inside a phase
        if (pix_done && (pixel_cnt != ADDR_W'(N_PIXELS - 1))) begin
          pixel_cnt <= pixel_cnt + ADDR_W'(1);
        end
        cmd_asm <= asm_nxt;
      end

      if (cmd_load) begin
        cmd_valid <= 1'b1;
        cmd_data  <= asm_nxt;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

`ifdef LOADER_STATUS_EN
  logic overflow;
  logic cmd_drop;
  logic status_rd;

  assign cmd_drop  = commit && cmd_valid && !cmd_ready;
  assign status_rd = hps_read && hps_chipselect && (hps_address == '1);

  // Sticky overflow; a drop in the same cycle as a status read keeps the flag set
  always_ff @(posedge clk50) begin
    if (reset) begin
      overflow     <= 1'b0;
      hps_readdata <= 8'h00;
    end else begin
      if (cmd_drop)       overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
      hps_readdata <= status_rd ? {loading, cmd_valid, overflow, state[1:0], 3'b000} : 8'h00;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_load_cmd_ctrl.sv
// Randomized self-checking bench for pixel_load_cmd_ctrl against a byte/slot level reference model.
// Build with LOADER_STATUS_EN defined to also cover the status read port.
module tb_pixel_load_cmd_ctrl;

  localparam int unsigned PB = 3;
  localparam int unsigned NP = 512;
  localparam int unsigned AW = 9;
  localparam int unsigned CB = 6;
  localparam int unsigned HW = 3;
  localparam logic [7:0]  CLEAR = 8'hFE;

  logic            clk50 = 1'b0;
  logic            reset;
  logic            src_valid;
  logic [7:0]      src_data;
  logic            src_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [8*PB-1:0] mem_din;
  logic            hps_write;
  logic            hps_chipselect;
  logic [HW-1:0]   hps_address;
  logic [7:0]      hps_writedata;
  logic            cmd_valid;
  logic [8*CB-1:0] cmd_data;
  logic            cmd_ready;
  logic            loading;
  logic            load_done;
`ifdef LOADER_STATUS_EN
  logic            hps_read;
  logic [7:0]      hps_readdata;
`endif

  always #10 clk50 = ~clk50;

  pixel_load_cmd_ctrl #(
    .PIXEL_BYTES(PB), .N_PIXELS(NP), .ADDR_W(AW), .CMD_BYTES(CB), .HPS_ADDR_W(HW), .CLEAR_CODE(CLEAR)
  ) dut (
    .clk50(clk50), .reset(reset),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .hps_write(hps_write), .hps_chipselect(hps_chipselect), .hps_address(hps_address),
    .hps_writedata(hps_writedata),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .loading(loading), .load_done(load_done)
`ifdef LOADER_STATUS_EN
    , .hps_read(hps_read), .hps_readdata(hps_readdata)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: phase (0 load, 1 run, 2 flush), byte/pixel counts, command slots
  int              m_st;
  int              m_acc;
  int              m_pix;
  logic [23:0]     m_word;
  logic [7:0]      m_slot [CB];
  logic            m_ovf;
  logic            e_src_ready, e_loading, e_load_done, e_mem_we, e_cmd_valid;
  logic [AW-1:0]   e_mem_addr;
  logic [8*PB-1:0] e_mem_din;
  logic [8*CB-1:0] e_cmd_data;
  logic [7:0]      e_rd;

  task automatic model_reset();
    m_st = 0; m_acc = 0; m_pix = 0; m_word = '0; m_ovf = 1'b0;
    for (int k = 0; k < CB; k++) m_slot[k] = 8'h00;
    e_src_ready = 1'b1; e_loading = 1'b1; e_load_done = 1'b0; e_mem_we = 1'b0;
    e_mem_addr = '0; e_mem_din = '0; e_cmd_valid = 1'b0; e_cmd_data = '0; e_rd = 8'h00;
  endtask

  function automatic logic [8*CB-1:0] pack_slots();
    logic [8*CB-1:0] d = '0;
    for (int k = 0; k < CB; k++) d = {d[8*CB-9:0], m_slot[k]};
    return d;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit
  task automatic tick(input bit r, input bit sv, input logic [7:0] sd, input bit hw, input bit cs,
                      input logic [2:0] ha, input logic [7:0] hd, input bit cr, input bit rd);
    bit wr, p_we, p_valid, clr, commit, drop, rd_hit;
    int p_st;
    logic [AW-1:0] p_addr;
    reset = r; src_valid = sv; src_data = sd; hps_write = hw; hps_chipselect = cs;
    hps_address = ha; hps_writedata = hd; cmd_ready = cr;
`ifdef LOADER_STATUS_EN
    hps_read = rd;
`endif
    @(posedge clk50);
    wr = hw && cs; rd_hit = rd && cs && (ha == 3'd7);
    p_we = e_mem_we; p_addr = e_mem_addr; p_valid = e_cmd_valid; p_st = m_st;
    commit = 1'b0; drop = 1'b0; clr = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      e_rd = rd_hit ? {e_loading, p_valid, m_ovf, 5'b0} : 8'h00;
      e_load_done = 1'b0;
      e_mem_we = 1'b0;
      if (p_st == 0) begin
        if (p_we && p_addr == AW'(NP - 1)) begin
          m_st = 1; e_loading = 1'b0; e_src_ready = 1'b0; e_load_done = 1'b1;
        end else if (sv) begin
          m_word = {m_word[15:0], sd};
          m_acc++;
          if (m_acc % PB == 0) begin
            e_mem_we = 1'b1; e_mem_addr = AW'(m_pix); e_mem_din = m_word; m_pix++;
          end
        end
      end else begin
        clr = (p_st == 1) && wr && (ha == 3'd0) && (hd == CLEAR);
        if (p_st == 1 && wr && !clr && int'(ha) < CB) begin
          m_slot[int'(ha)] = hd;
          commit = (int'(ha) == CB - 1);
        end
        if (commit && p_valid && !cr) drop = 1'b1;
        else if (commit) begin e_cmd_valid = 1'b1; e_cmd_data = pack_slots(); end
        else if (p_valid && cr) e_cmd_valid = 1'b0;
        if (clr) m_st = p_valid ? 2 : 0;
        else if (p_st == 2 && !p_valid) m_st = 0;
        if (m_st == 0) begin
          m_acc = 0; m_pix = 0; m_word = '0; e_loading = 1'b1; e_src_ready = 1'b1;
          for (int k = 0; k < CB; k++) m_slot[k] = 8'h00;
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (rd_hit) m_ovf = 1'b0;
    end
    #1;
  endtask

  task automatic hps_tick(input bit hw, input logic [2:0] ha, input logic [7:0] hd, input bit cr);
    tick(1'b0, 1'b0, 8'h00, hw, 1'b1, ha, hd, cr, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    nvec++;
    if ({src_ready, loading, load_done, mem_we, mem_addr, mem_din, cmd_valid, cmd_data} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 24'd0, 1'b0, 48'd0}) begin
      nerr++;
      $display("FAIL reset_state: got rdy=%b ld=%b done=%b we=%b addr=%h din=%h cv=%b cd=%h want 1 1 0 0 0 0 0 0",
               src_ready, loading, load_done, mem_we, mem_addr, mem_din, cmd_valid, cmd_data);
    end
`ifdef LOADER_STATUS_EN
    nvec++;
    if (hps_readdata !== 8'h00) begin
      nerr++; $display("FAIL reset_readdata: got %h want 00", hps_readdata);
    end
`endif
  endtask

  // mode 0: src_valid always, 1: toggling, 2: random
  task automatic test_load(input int mode);
    int cyc = 0, dut_we = 0, dut_done = 0;
    bit sv;
    logic [23:0] w0 = 'x, wlast = 'x;
    while (!e_load_done && cyc < 8000) begin
      sv = (m_acc < NP * PB) && ((mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom % 4 != 0));
      tick(1'b0, sv, sv ? 8'(m_acc) : 8'($urandom), 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      cyc++;
      if (mem_we) dut_we++;
      if (load_done) dut_done++;
      nvec++;
      if ({src_ready, loading, load_done, mem_we} !== {e_src_ready, e_loading, e_load_done, e_mem_we}) begin
        nerr++;
        $display("FAIL load_ctrl(mode %0d cyc %0d): got rdy/ld/done/we=%b%b%b%b want %b%b%b%b", mode, cyc,
                 src_ready, loading, load_done, mem_we, e_src_ready, e_loading, e_load_done, e_mem_we);
      end
      if (e_mem_we) begin
        nvec++;
        if (mem_addr !== e_mem_addr || mem_din !== e_mem_din) begin
          nerr++;
          $display("FAIL load_word: got addr=%0d din=%h want addr=%0d din=%h", mem_addr, mem_din,
                   e_mem_addr, e_mem_din);
        end
        if (e_mem_addr == 0) w0 = mem_din;
        if (e_mem_addr == AW'(NP - 1)) wlast = mem_din;
      end
    end
    nvec++;
    if (cyc >= 8000) begin nerr++; $display("FAIL load_timeout: got %0d cycles want < 8000", cyc); end
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    nvec++;
    if (load_done !== 1'b0 || loading !== 1'b0 || src_ready !== 1'b0) begin
      nerr++; $display("FAIL load_done_pulse: got done=%b ld=%b rdy=%b want 0 0 0", load_done, loading, src_ready);
    end
    nvec++;
    if (dut_we != 512 || dut_done != 1) begin
      nerr++; $display("FAIL load_counts: got we=%0d done=%0d want 512 1", dut_we, dut_done);
    end
    nvec++;
    if (w0 !== 24'h000102 || wlast !== 24'hFDFEFF) begin
      nerr++; $display("FAIL load_ends: got w0=%h w511=%h want 000102 fdfeff", w0, wlast);
    end
  endtask

  task automatic test_command();
    for (int k = 0; k < CB; k++) hps_tick(1'b1, 3'(k), 8'(8'h11 * (k + 1)), 1'b0);
    for (int h = 0; h < 3; h++) begin
      nvec++;
      if (cmd_valid !== 1'b1 || cmd_data !== 48'h112233445566) begin
        nerr++; $display("FAIL cmd_first(hold %0d): got cv=%b cd=%h want 1 112233445566", h, cmd_valid, cmd_data);
      end
      hps_tick(1'b0, 3'd0, 8'h00, 1'b0);
    end
    hps_tick(1'b1, 3'd5, 8'h77, 1'b0);
    nvec++;
    if (cmd_valid !== 1'b1 || cmd_data !== 48'h112233445566) begin
      nerr++; $display("FAIL cmd_overflow_drop: got cv=%b cd=%h want 1 112233445566", cmd_valid, cmd_data);
    end
`ifdef LOADER_STATUS_EN
    for (int r = 0; r < 2; r++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b1);
      nvec++;
      if ((hps_readdata & 8'hE7) !== (e_rd & 8'hE7) || hps_readdata[5] !== (r == 0)) begin
        nerr++; $display("FAIL status_read%0d: got %h want %h (state bits masked)", r, hps_readdata, e_rd);
      end
    end
`endif
    hps_tick(1'b0, 3'd0, 8'h00, 1'b1);
    nvec++;
    if (cmd_valid !== 1'b0) begin nerr++; $display("FAIL cmd_accept: got cv=%b want 0", cmd_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < CB; k++) hps_tick(1'b1, 3'(k), 8'(8'hA0 + k), 1'b0);
    hps_tick(1'b1, 3'd5, 8'h5A, 1'b1);
    nvec++;
    if (cmd_valid !== 1'b1 || cmd_data !== 48'hA0A1A2A3A45A) begin
      nerr++; $display("FAIL commit_with_ready: got cv=%b cd=%h want 1 a0a1a2a3a45a", cmd_valid, cmd_data);
    end
    for (int k = 0; k < 4; k++) begin
      hps_tick(1'b1, 3'd5, 8'($urandom), 1'b1);
      nvec++;
      if (cmd_valid !== e_cmd_valid || cmd_data !== e_cmd_data) begin
        nerr++; $display("FAIL b2b_commit%0d: got cv=%b cd=%h want %b %h", k, cmd_valid, cmd_data, e_cmd_valid, e_cmd_data);
      end
    end
  endtask

  task automatic test_random_run();
    logic [2:0] ha;
    logic [7:0] hd;
    for (int i = 0; i < 400; i++) begin
      ha = 3'($urandom);
      hd = 8'($urandom);
      if (ha == 3'd0 && hd == CLEAR) hd = 8'h00;
      tick(1'b0, 1'($urandom), 8'($urandom), ($urandom % 2 == 0), ($urandom % 8 != 0), ha, hd,
           ($urandom % 3 == 0), ($urandom % 6 == 0));
      nvec++;
      if ({src_ready, loading, load_done, mem_we, cmd_valid} !==
          {e_src_ready, e_loading, e_load_done, e_mem_we, e_cmd_valid} ||
          (e_cmd_valid && cmd_data !== e_cmd_data)) begin
        nerr++;
        $display("FAIL run_random(%0d): got rdy/ld/done/we/cv=%b%b%b%b%b cd=%h want %b%b%b%b%b %h", i,
                 src_ready, loading, load_done, mem_we, cmd_valid, cmd_data,
                 e_src_ready, e_loading, e_load_done, e_mem_we, e_cmd_valid, e_cmd_data);
      end
`ifdef LOADER_STATUS_EN
      nvec++;
      if ((hps_readdata & 8'hE7) !== (e_rd & 8'hE7)) begin
        nerr++; $display("FAIL run_status(%0d): got %h want %h (state bits masked)", i, hps_readdata, e_rd);
      end
`endif
    end
  endtask

  task automatic test_clear_flush();
    logic [8*CB-1:0] held;
    hps_tick(1'b1, 3'd5, 8'h3C, 1'b0);
    held = e_cmd_data;
    hps_tick(1'b1, 3'd0, CLEAR, 1'b0);
    nvec++;
    if (cmd_valid !== 1'b1 || src_ready !== 1'b0 || loading !== 1'b0 || m_st != 2) begin
      nerr++; $display("FAIL clear_to_flush: got cv=%b rdy=%b ld=%b want 1 0 0", cmd_valid, src_ready, loading);
    end
    hps_tick(1'b1, 3'd5, 8'h99, 1'b0);
    hps_tick(1'b1, 3'd0, CLEAR, 1'b0);
    nvec++;
    if (cmd_valid !== 1'b1 || cmd_data !== held || src_ready !== 1'b0) begin
      nerr++; $display("FAIL flush_ignores_hps: got cv=%b cd=%h rdy=%b want 1 %h 0", cmd_valid, cmd_data, src_ready, held);
    end
    hps_tick(1'b0, 3'd0, 8'h00, 1'b1);
    nvec++;
    if (cmd_valid !== 1'b0 || src_ready !== 1'b0) begin
      nerr++; $display("FAIL flush_drain: got cv=%b rdy=%b want 0 0", cmd_valid, src_ready);
    end
    hps_tick(1'b0, 3'd0, 8'h00, 1'b0);
    nvec++;
    if (src_ready !== 1'b1 || loading !== 1'b1) begin
      nerr++; $display("FAIL flush_to_load: got rdy=%b ld=%b want 1 1", src_ready, loading);
    end
    test_load(1);
    hps_tick(1'b1, 3'd5, 8'hAB, 1'b0);
    nvec++;
    if (cmd_valid !== 1'b1 || cmd_data !== 48'h0000000000AB) begin
      nerr++; $display("FAIL slots_cleared: got cv=%b cd=%h want 1 0000000000ab", cmd_valid, cmd_data);
    end
  endtask

  task automatic test_clear_direct();
    hps_tick(1'b0, 3'd0, 8'h00, 1'b1);
    hps_tick(1'b1, 3'd0, CLEAR, 1'b0);
    nvec++;
    if (src_ready !== 1'b1 || loading !== 1'b1 || cmd_valid !== 1'b0) begin
      nerr++; $display("FAIL clear_direct: got rdy=%b ld=%b cv=%b want 1 1 0", src_ready, loading, cmd_valid);
    end
    test_load(2);
  endtask

  task automatic test_reset_mid_load();
    int cyc = 0;
    tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    while (m_pix < 100 && cyc < 1000) begin
      tick(1'b0, 1'b1, 8'(m_acc), 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      cyc++;
    end
    tick(1'b0, 1'b1, 8'(m_acc), 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    nvec++;
    if (mem_addr !== 9'd99 || loading !== 1'b1) begin
      nerr++; $display("FAIL mid_load_progress: got addr=%0d ld=%b want 99 1", mem_addr, loading);
    end
    tick(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    nvec++;
    if ({src_ready, loading, load_done, mem_we, mem_addr, mem_din, cmd_valid, cmd_data} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 24'd0, 1'b0, 48'd0}) begin
      nerr++;
      $display("FAIL mid_load_reset: got rdy=%b ld=%b done=%b we=%b addr=%h din=%h cv=%b cd=%h want 1 1 0 0 0 0 0 0",
               src_ready, loading, load_done, mem_we, mem_addr, mem_din, cmd_valid, cmd_data);
    end
    test_load(0);
  endtask

  initial begin
    reset = 1'b1; src_valid = 1'b0; src_data = 8'h00; hps_write = 1'b0; hps_chipselect = 1'b0;
    hps_address = '0; hps_writedata = 8'h00; cmd_ready = 1'b0;
`ifdef LOADER_STATUS_EN
    hps_read = 1'b0;
`endif
    model_reset();
    test_reset();
    test_load(0);
    test_command();
    test_back_to_back();
    test_random_run();
    test_clear_flush();
    test_clear_direct();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
